lab6_result_fifo: RTL and testbench

LAB6_RESULT_FIFO -- requirements
Module: lab6_result_fifo

---
 rtl/lab6_pkg.sv | 8 +
 rtl/lab6_sync_fifo.sv | 59 +++++
 rtl/lab6_result_fifo.sv | 70 +++++++
 tb/tb_lab6_result_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab6_pkg.sv
// Shared constants and result type for the lab6 filter datapath and its
// result FIFO.
package lab6_pkg;
  localparam int RESULT_W   = 10;
  localparam int FIFO_DEPTH = 8;

  typedef logic signed [RESULT_W-1:0] result_t;
endpackage

// File: rtl/lab6_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: register storage, wrapping
// pointers and occupancy count.
module lab6_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic signed [W-1:0]       din,
  output logic signed [W-1:0]       dout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic signed [W-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                wr_en;

  assign full  = (count_q == FULL_CNT);
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/lab6_result_fifo.sv
// Result FIFO for the lab6 filter: captures one entry per rising edge of
// ordy, tracks a sticky overflow flag and the most positive result seen.
module lab6_result_fifo
  import lab6_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = RESULT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ordy,
  input  logic signed [W-1:0]    din,
  input  logic                   clr_ovf,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic signed [W-1:0]    dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic signed [W-1:0]    peak
);
  function automatic logic signed [W-1:0] most_negative();
    return {1'b1, {(W-1){1'b0}}};
  endfunction

  logic                ordy_q, ordy_d;
  logic                overflow_q, overflow_d;
  logic signed [W-1:0] peak_q, peak_d;
  logic                push, pop, full, drop;

  assign push      = ordy & ~ordy_q;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign drop      = push & full & ~pop;
  assign overflow  = overflow_q;
  assign peak      = peak_q;

  lab6_sync_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full)
  );

  always_comb begin
    ordy_d     = ordy;
    overflow_d = overflow_q;
    peak_d     = peak_q;
    // Clear first so a coincident drop wins.
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
    if (push && (din > peak_q)) peak_d = din;
  end

  // ordy_q resets high so a level already present at release is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ordy_q     <= 1'b1;
      overflow_q <= 1'b0;
      peak_q     <= most_negative();
    end else begin
      ordy_q     <= ordy_d;
      overflow_q <= overflow_d;
      peak_q     <= peak_d;
    end
  end
endmodule

// File: tb/tb_lab6_result_fifo.sv
// Self-checking bench for lab6_result_fifo: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_lab6_result_fifo;
  import lab6_pkg::*;

  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ordy = 1'b0;
  result_t       din = '0;
  logic          clr_ovf = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  result_t       dout;
  logic [3:0]    count;
  logic          overflow;
  result_t       peak;

  int checks = 0;
  int failures = 0;

  lab6_result_fifo #(.DEPTH(DEPTH), .W(RESULT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ordy      (ordy),
    .din       (din),
    .clr_ovf   (clr_ovf),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dout      (dout),
    .count     (count),
    .overflow  (overflow),
    .peak      (peak)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then one idle cycle with ordy low so the next rise is a push.
  task automatic do_reset();
    ordy = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic produce(input int v);
    din = result_t'(v);
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++;
    if (peak !== 10'h200) begin failures++; $display("FAIL reset_peak got=%h exp=200", peak); end
  endtask

  task automatic test_single_push();
    do_reset();
    din = 10'sd100;
    ordy = 1'b1;
    tick();
    checks++;
    if (count !== 4'd1 || out_valid !== 1'b1 || dout !== 10'sd100)
      begin failures++; $display("FAIL single_push got cnt=%0d v=%b d=%0d exp cnt=1 v=1 d=100", count, out_valid, dout); end
    repeat (4) tick();
    checks++;
    if (count !== 4'd1 || dout !== 10'sd100 || peak !== 10'sd100)
      begin failures++; $display("FAIL single_hold got cnt=%0d d=%0d pk=%0d exp 1 100 100", count, dout, peak); end
    ordy = 1'b0;
    tick();
  endtask

  task automatic test_overflow_drain();
    int exp_vals[8] = '{-5, 1, 2, 3, 4, 5, 6, 7};
    do_reset();
    produce(-5);
    for (int i = 1; i <= 8; i++) produce(i);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1 || peak !== 10'sd8)
      begin failures++; $display("FAIL ovf_fill got cnt=%0d ovf=%b pk=%0d exp 8 1 8", count, overflow, peak); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || dout !== result_t'(exp_vals[i]))
        begin failures++; $display("FAIL ovf_drain[%0d] got v=%b d=%0d exp d=%0d", i, out_valid, dout, exp_vals[i]); end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL ovf_empty got cnt=%0d v=%b exp 0 0", count, out_valid); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) produce(10 + i);
    din = 10'sd99; ordy = 1'b1; out_ready = 1'b1;
    tick();
    ordy = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (count !== 4'd8 || overflow !== 1'b0)
      begin failures++; $display("FAIL full_pushpop got cnt=%0d ovf=%b exp 8 0", count, overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout !== result_t'((i < 7) ? 11 + i : 99))
        begin failures++; $display("FAIL full_drain[%0d] got=%0d exp=%0d", i, dout, (i < 7) ? 11 + i : 99); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clr_ovf();
    do_reset();
    for (int i = 0; i < 9; i++) produce(i);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL clr_plain got=%b exp=0", overflow); end
    din = 10'sd50; ordy = 1'b1; clr_ovf = 1'b1;
    tick();
    ordy = 1'b0; clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 4'd8)
      begin failures++; $display("FAIL clr_vs_drop got ovf=%b cnt=%0d exp 1 8", overflow, count); end
    tick();
  endtask

  task automatic test_ordy_through_reset();
    ordy = 1'b1; din = 10'sd77;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (count !== 4'd0 || peak !== 10'h200)
      begin failures++; $display("FAIL ordy_held got cnt=%0d pk=%h exp 0 200", count, peak); end
    ordy = 1'b0;
    tick();
    din = 10'sd33; ordy = 1'b1;
    tick();
    checks++;
    if (count !== 4'd1 || peak !== 10'sd33 || dout !== 10'sd33)
      begin failures++; $display("FAIL ordy_rerise got cnt=%0d pk=%0d d=%0d exp 1 33 33", count, peak, dout); end
    ordy = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 9; i++) produce(i + 20);
    out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd3) begin failures++; $display("FAIL mid_pre got cnt=%0d exp 3", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0)
      begin failures++; $display("FAIL mid_reset got cnt=%0d v=%b ovf=%b exp 0 0 0", count, out_valid, overflow); end
    tick();
    produce(-1);
    checks++;
    if (out_valid !== 1'b1 || dout !== -10'sd1 || count !== 4'd1)
      begin failures++; $display("FAIL mid_readback got v=%b d=%0d cnt=%0d exp 1 -1 1", out_valid, dout, count); end
  endtask

  task automatic test_random();
    int      q[$];
    int      m_peak;
    bit      m_ovf;
    bit      prev_ordy;
    bit      m_push, m_pop, m_full, m_drop;
    int      v;
    do_reset();
    q.delete();
    m_peak = -512; m_ovf = 1'b0; prev_ordy = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ordy      = 1'($urandom_range(0, 1));
      din       = result_t'($urandom_range(0, 1023));
      out_ready = (cyc < 300) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      v         = int'(din);
      m_push = ordy && !prev_ordy;
      m_pop  = (q.size() > 0) && out_ready;
      m_full = (q.size() == DEPTH);
      m_drop = m_push && m_full && !m_pop;
      if (m_push && v > m_peak) m_peak = v;
      if (m_pop) void'(q.pop_front());
      if (m_push && !m_drop) q.push_back(v);
      if (clr_ovf) m_ovf = 1'b0;
      if (m_drop) m_ovf = 1'b1;
      prev_ordy = ordy;
      tick();
      checks++;
      if (count !== 4'(q.size()) || overflow !== m_ovf || peak !== result_t'(m_peak))
        begin failures++; $display("FAIL rand_state[%0d] got cnt=%0d ovf=%b pk=%0d exp cnt=%0d ovf=%b pk=%0d", cyc, count, overflow, peak, q.size(), m_ovf, m_peak); end
      if (q.size() > 0) begin
        checks++;
        if (out_valid !== 1'b1 || dout !== result_t'(q[0]))
          begin failures++; $display("FAIL rand_head[%0d] got v=%b d=%0d exp d=%0d", cyc, out_valid, dout, q[0]); end
      end
    end
    ordy = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overflow_drain();
    test_full_push_pop();
    test_clr_ovf();
    test_ordy_through_reset();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
